// File: rtl/traffic_pkg.sv
// Shared types and default timing for the traffic phase scheduler.
package traffic_pkg;

    localparam int DEF_GREEN_MIN = 8;
    localparam int DEF_GREEN_MAX = 16;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 5;
    localparam int DEF_CNT_W     = 5;

    typedef enum logic [2:0] {
        ST_MG   = 3'd0,
        ST_MY   = 3'd1,
        ST_AR1  = 3'd2,
        ST_WALK = 3'd3,
        ST_SG   = 3'd4,
        ST_SY   = 3'd5,
        ST_AR2  = 3'd6
    } state_e;

    typedef struct packed {
        logic r1;
        logic y1;
        logic g1;
        logic r2;
        logic y2;
        logic g2;
        logic walk;
    } lamps_t;

    // Lamp pattern for each phase; unused encodings fall back to the
    // main-green pattern so a road never goes dark.
    function automatic lamps_t decode_lamps(state_e s);
        lamps_t l;
        l = '0;
        case (s)
            ST_MG:   begin l.g1 = 1'b1; l.r2 = 1'b1; end
            ST_MY:   begin l.y1 = 1'b1; l.r2 = 1'b1; end
            ST_AR1,
            ST_AR2:  begin l.r1 = 1'b1; l.r2 = 1'b1; end
            ST_WALK: begin l.r1 = 1'b1; l.r2 = 1'b1; l.walk = 1'b1; end
            ST_SG:   begin l.r1 = 1'b1; l.g2 = 1'b1; end
            ST_SY:   begin l.r1 = 1'b1; l.y2 = 1'b1; end
            default: begin l.g1 = 1'b1; l.r2 = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// In-phase dwell counter: clears on phase change, holds at a saturation
// limit, flags when it equals the current phase's terminal value.
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] sat_lim_i,
    input  logic [CNT_W-1:0] term_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count up each cycle, restart on clear, stop at the saturation limit.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != sat_lim_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection controller with pedestrian walk phase.
// Main road rests in green; side-road demand or a pending pedestrian
// request pulls it through yellow / all-red into the served phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic m,
    input  logic ped_req,
    output logic r1,
    output logic y1,
    output logic g1,
    output logic r2,
    output logic y2,
    output logic g2,
    output logic walk,
    output logic ped_pending
);

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

    state_e           state_q, state_d;
    lamps_t           lamps_q;
    logic             ped_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_val;
    logic [CNT_W-1:0] sat_lim;
    logic             term;
    logic             chg;
    logic             enter_walk;

    // Terminal value and saturation limit for the phase currently held.
    always_comb begin
        term_val = GMIN_M1;
        sat_lim  = '1;
        case (state_q)
            ST_MG:         begin term_val = GMIN_M1; sat_lim = GMIN_M1; end
            ST_MY, ST_SY:  term_val = YEL_M1;
            ST_AR1, ST_AR2: term_val = AR_M1;
            ST_WALK:       term_val = WALK_M1;
            ST_SG:         term_val = GMAX_M1;
            default:       term_val = GMIN_M1;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (chg),
        .sat_lim_i  (sat_lim),
        .term_val_i (term_val),
        .cnt_o      (cnt),
        .term_o     (term)
    );

    // Phase sequencing; m is sampled live at each exit check, never latched.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MG:   if (term && (m || ped_q)) state_d = ST_MY;
            ST_MY:   if (term) state_d = ST_AR1;
            ST_AR1:  if (term) state_d = ped_q ? ST_WALK : ST_SG;
            ST_WALK: if (term) state_d = m ? ST_SG : ST_AR2;
            ST_SG:   if (term || (cnt >= GMIN_M1 && !m)) state_d = ST_SY;
            ST_SY:   if (term) state_d = ST_AR2;
            ST_AR2:  if (term) state_d = ST_MG;
            default: state_d = ST_MG;
        endcase
    end

    assign chg        = (state_d != state_q);
    assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

    // State, registered lamp decode and pedestrian latch (new request beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_MG;
            lamps_q <= decode_lamps(ST_MG);
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lamps_q <= decode_lamps(state_d);
            ped_q   <= ped_req | (ped_q & ~enter_walk);
        end
    end

    assign r1          = lamps_q.r1;
    assign y1          = lamps_q.y1;
    assign g1          = lamps_q.g1;
    assign r2          = lamps_q.r2;
    assign y2          = lamps_q.y2;
    assign g2          = lamps_q.g2;
    assign walk        = lamps_q.walk;
    assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler at default timing.
// Each vector drives one clock edge and names the lamps/pending flag
// expected just after that edge.
module tb_traffic_phase_scheduler;

    // lamp vector order: {r1, y1, g1, r2, y2, g2, walk}
    localparam logic [6:0] L_MG = 7'b0011000;
    localparam logic [6:0] L_MY = 7'b0101000;
    localparam logic [6:0] L_AR = 7'b1001000;
    localparam logic [6:0] L_WK = 7'b1001001;
    localparam logic [6:0] L_SG = 7'b1000010;
    localparam logic [6:0] L_SY = 7'b1000100;

    typedef struct {
        logic       rst;
        logic       m;
        logic       ped;
        logic [6:0] lamps;
        logic       pp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m = 1'b0;
    logic ped_req = 1'b0;
    logic r1, y1, g1, r2, y2, g2, walk, ped_pending;

    int n_chk = 0;
    int n_fail = 0;
    vec_t vq[$];

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .m           (m),
        .ped_req     (ped_req),
        .r1          (r1),
        .y1          (y1),
        .g1          (g1),
        .r2          (r2),
        .y2          (y2),
        .g2          (g2),
        .walk        (walk),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic mm, input logic p,
                       input logic [6:0] l, input logic pp, input int n);
        vec_t v;
        v.rst = r; v.m = mm; v.ped = p; v.lamps = l; v.pp = pp;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_check(input string tag, input logic [6:0] l, input logic pp);
        logic [6:0] got;
        @(posedge clk);
        #1;
        got = {r1, y1, g1, r2, y2, g2, walk};
        chk({tag, " lamps"}, int'(got), int'(l));
        chk({tag, " ped_pending"}, int'(ped_pending), int'(pp));
        chk({tag, " one lamp per road"},
            int'(($countones({r1, y1, g1}) == 1) && ($countones({r2, y2, g2}) == 1)), 1);
    endtask

    initial begin
        // idle: no demand keeps main green
        add(1,0,0,L_MG,0,1); add(0,0,0,L_MG,0,50);
        // side demand held: full cycle with side green at its maximum
        add(1,0,0,L_MG,0,1); add(0,1,0,L_MG,0,7); add(0,1,0,L_MY,0,3);
        add(0,1,0,L_AR,0,1); add(0,1,0,L_SG,0,16); add(0,1,0,L_SY,0,3);
        add(0,1,0,L_AR,0,1); add(0,1,0,L_MG,0,8); add(0,1,0,L_MY,0,1);
        // side demand drops in SG cycle 3: SG ends at minimum (reset beats m)
        add(1,1,0,L_MG,0,1); add(0,1,0,L_MG,0,7); add(0,1,0,L_MY,0,3);
        add(0,1,0,L_AR,0,1); add(0,1,0,L_SG,0,3); add(0,0,0,L_SG,0,5);
        add(0,0,0,L_SY,0,3); add(0,0,0,L_AR,0,1); add(0,0,0,L_MG,0,4);
        // pedestrian only (reset beats ped_req)
        add(1,0,1,L_MG,0,1); add(0,0,0,L_MG,0,1); add(0,0,1,L_MG,1,1);
        add(0,0,0,L_MG,1,5); add(0,0,0,L_MY,1,3); add(0,0,0,L_AR,1,1);
        add(0,0,0,L_WK,0,5); add(0,0,0,L_AR,0,1); add(0,0,0,L_MG,0,3);
        // pedestrian + side demand, re-request during walk, reset in SG cycle 4
        add(1,0,0,L_MG,0,1); add(0,1,1,L_MG,1,1); add(0,1,0,L_MG,1,6);
        add(0,1,0,L_MY,1,3); add(0,1,0,L_AR,1,1); add(0,1,0,L_WK,0,2);
        add(0,1,1,L_WK,1,1); add(0,1,0,L_WK,1,2); add(0,1,0,L_SG,1,4);
        add(1,1,0,L_MG,0,1); add(0,1,0,L_MG,0,7); add(0,1,0,L_MY,0,1);
        // request on the walk-entry edge survives, then forces another cycle
        add(1,0,0,L_MG,0,1); add(0,0,1,L_MG,1,1); add(0,0,0,L_MG,1,6);
        add(0,0,0,L_MY,1,3); add(0,0,0,L_AR,1,1); add(0,0,1,L_WK,1,1);
        add(0,0,0,L_WK,1,4); add(0,0,0,L_AR,1,1); add(0,0,0,L_MG,1,8);
        add(0,0,0,L_MY,1,3); add(0,0,0,L_AR,1,1); add(0,0,0,L_WK,0,1);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; m = vq[i].m; ped_req = vq[i].ped;
            step_check($sformatf("vec%0d", i), vq[i].lamps, vq[i].pp);
        end

        // short side-demand pulse that drops before the MG exit check is dropped
        rst = 1'b1; m = 1'b0; ped_req = 1'b0;
        step_check("pulse rst", L_MG, 1'b0);
        rst = 1'b0; m = 1'b1;
        step_check("pulse hi0", L_MG, 1'b0);
        step_check("pulse hi1", L_MG, 1'b0);
        m = 1'b0;
        for (int i = 0; i < 12; i++) step_check($sformatf("pulse lo%0d", i), L_MG, 1'b0);
        // late demand after saturation is served on the very next edge
        m = 1'b1;
        step_check("late demand", L_MY, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 8, minimum green dwell in cycles, both roads.
REQ-002 Parameter GREEN_MAX, default 16, maximum side-road green dwell in cycles.
REQ-003 Parameter YELLOW_T, default 3, yellow dwell in cycles.
REQ-004 Parameter ALLRED_T, default 1, all-red clearance dwell in cycles.
REQ-005 Parameter WALK_T, default 5, pedestrian walk dwell in cycles.
REQ-006 Parameter CNT_W, default 5, timer width; SHALL satisfy 2**CNT_W > max(all dwell parameters).
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 m  input  1  side-road vehicle sensor, level-sensitive, synchronous to clk.
REQ-010 ped_req  input  1  pedestrian request, one-cycle pulse or level.
REQ-011 r1, y1, g1  output  1 each  main-road lamps.
REQ-012 r2, y2, g2  output  1 each  side-road lamps.
REQ-013 walk  output  1  pedestrian walk lamp.
REQ-014 ped_pending  output  1  latched, not-yet-served pedestrian request.

Function
REQ-015 States: MG (main green), MY, AR1, WALK, SG (side green), SY, AR2.
REQ-016 Outputs are a Moore decode of the state register only: MG g1,r2; MY y1,r2; AR1/AR2 r1,r2; WALK r1,r2,walk; SG r1,g2; SY r1,y2; all other outputs 0.
REQ-017 Exactly one lamp per road SHALL be high in every cycle; g1/y1 and g2/y2 never high together.
REQ-018 Timer clears to 0 on every state change and increments each cycle in-state; saturates in MG at GREEN_MIN-1.
REQ-019 MG -> MY when timer >= GREEN_MIN-1 and (m or ped_pending); else stay MG indefinitely.
REQ-020 MY -> AR1 when timer == YELLOW_T-1; SY -> AR2 when timer == YELLOW_T-1.
REQ-021 AR1 -> WALK if ped_pending, else SG, when timer == ALLRED_T-1.
REQ-022 WALK -> SG if m, else AR2, when timer == WALK_T-1.
REQ-023 SG -> SY when timer == GREEN_MAX-1, or timer >= GREEN_MIN-1 and m == 0.
REQ-024 AR2 -> MG when timer == ALLRED_T-1.
REQ-025 ped_pending sets on any cycle with ped_req=1, clears on the transition into WALK; set wins over clear in the same cycle.
REQ-026 m is not latched; a pulse that has dropped before MG's exit check is not served.

Reset
REQ-027 rst=1 at a rising edge: state MG, timer 0, ped_pending 0, regardless of current state.
REQ-028 Output values during and after reset: g1=1, r2=1, all other outputs 0.
REQ-029 rst overrides ped_req and m in the same cycle.

Structure
REQ-030 Shared package traffic_pkg holds the state enum and the default timing constants.
REQ-031 One sub-module, phase_timer: CNT_W counter with clear, saturate limit and terminal-compare output.

Verification (defaults)
REQ-032 rst, then m=0, ped_req=0 for 50 cycles -> g1=1, r2=1 every cycle; no transitions.
REQ-033 m=1 held from reset release -> MG 8, MY 3, AR1 1, SG 16, SY 3, AR2 1 cycles, then MG.
REQ-034 m=1 until the 3rd SG cycle, then 0 -> SG lasts exactly 8 cycles, then SY.
REQ-035 ped_req pulse at cycle 2, m=0 -> MG 8, MY 3, AR1 1, WALK 5 (walk=1, r1=r2=1), AR2 1, MG; ped_pending 0 after WALK entry.
REQ-036 ped_req and m=1 together -> WALK 5 then SG; ped_req during WALK -> ped_pending=1 at WALK exit.
REQ-037 rst pulse during SG cycle 4 -> next cycle g1=1, r2=1, ped_pending=0; GREEN_MIN restarts from 0.
